// File: rtl/obc_pkg.sv
// Shared types and constants for the OBC distributed-arithmetic DFT plane sequencer.
package obc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } obc_state_e;

    localparam int OBC_ROM_W = 32;
    localparam int OBC_NPTS  = 16;

    // Accumulator width: the ROM partial sum grows by one bit per plane weight.
    function automatic int acc_w(input int w);
        return OBC_ROM_W + w;
    endfunction

endpackage

// File: rtl/obc_plane_sequencer_if.sv
// Handshake, sample, ROM-stage and result signals of the OBC plane sequencer.
// slave = the sequencer; master = sample buffer, ROM stage and result consumer.
interface obc_plane_sequencer_if #(
    parameter int W = 8
) ();
    localparam int ACC_W = obc_pkg::acc_w(W);

    logic                                  in_valid;
    logic                                  in_ready;
    logic [obc_pkg::OBC_NPTS*W-1:0]        in_data;
    logic [obc_pkg::OBC_ROM_W-1:0]         offset;
    logic [obc_pkg::OBC_NPTS-1:0]          plane_x;
    logic                                  plane_i;
    logic [obc_pkg::OBC_ROM_W-1:0]         romout;
    logic                                  out_valid;
    logic                                  out_ready;
    logic [ACC_W-1:0]                      out_data;
    logic                                  busy;

    modport master (
        output in_valid, in_data, offset, romout, out_ready,
        input  in_ready, plane_x, plane_i, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, offset, romout, out_ready,
        output in_ready, plane_x, plane_i, out_valid, out_data, busy
    );

endinterface

// File: rtl/obc_plane_shreg.sv
// 16-lane parallel-load right-shift register; lane LSBs form the current bit-plane.
module obc_plane_shreg
    import obc_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  shift,
    input  logic [OBC_NPTS*W-1:0] din,
    output logic [OBC_NPTS-1:0]   plane
);

    logic [W-1:0] lane [OBC_NPTS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < OBC_NPTS; i++) lane[i] <= '0;
        end else if (load) begin
            for (int i = 0; i < OBC_NPTS; i++) lane[i] <= din[i*W +: W];
        end else if (shift) begin
            for (int i = 0; i < OBC_NPTS; i++) lane[i] <= lane[i] >> 1;
        end
    end

    always_comb begin
        plane = '0;
        for (int i = 0; i < OBC_NPTS; i++) plane[i] = lane[i][0];
    end

endmodule

// File: rtl/obc_plane_sequencer.sv
// Bit-serial plane driver and shift-accumulator for one OBC DFT ROM stage.
// Define OBC_ROM_PIPE_EN when the ROM stage output is registered (adds DRAIN).
//
// state | meaning
// IDLE  | waiting for a sample vector, in_ready high
// SHIFT | driving plane b = 0..W-1 and accumulating the ROM partial sum
// DRAIN | one extra cycle absorbing the last plane from a registered ROM stage
// DONE  | result held on out_data until out_ready; may reload in the same cycle
module obc_plane_sequencer
    import obc_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    obc_plane_sequencer_if.slave bus
);

    localparam int ACC_W = acc_w(W);

    obc_state_e            state_q, state_d;
    logic [3:0]            b_q;
    logic [ACC_W-1:0]      acc_q;
    logic                  in_ready_c;
    logic                  in_ready;
    logic                  load;
    logic                  last_plane;
    logic                  acc_en;
    logic [3:0]            acc_shamt;
    logic [ACC_W-1:0]      rom_ext;
    logic [ACC_W-1:0]      offset_ext;
    logic [ACC_W-1:0]      term;
    logic [OBC_NPTS-1:0]   plane;

    assign last_plane = (b_q == 4'(W-1));
    assign rom_ext    = {{W{bus.romout[OBC_ROM_W-1]}}, bus.romout};
    assign offset_ext = {{W{bus.offset[OBC_ROM_W-1]}}, bus.offset};
    assign term       = rom_ext << acc_shamt;

    // in_ready must read low for as long as reset is held.
    assign in_ready = in_ready_c & ~rst;
    assign load     = bus.in_valid & in_ready;

    obc_plane_shreg #(.W(W)) u_shreg (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (state_q == SHIFT),
        .din   (bus.in_data),
        .plane (plane)
    );

`ifdef OBC_ROM_PIPE_EN
    // Registered ROM: the partial sum for plane b arrives a cycle later.
    logic [3:0] b_d;
    logic       acc_en_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_d      <= '0;
            acc_en_d <= 1'b0;
        end else begin
            b_d      <= b_q;
            acc_en_d <= (state_q == SHIFT);
        end
    end

    assign acc_en    = acc_en_d;
    assign acc_shamt = b_d;
`else
    assign acc_en    = (state_q == SHIFT);
    assign acc_shamt = b_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            b_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                b_q   <= '0;
                acc_q <= offset_ext;
            end else begin
                if (state_q == SHIFT) b_q <= b_q + 4'd1;
                if (acc_en) acc_q <= acc_q + term;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        in_ready_c    = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) state_d = SHIFT;
            end
            SHIFT: begin
                bus.busy = 1'b1;
                if (last_plane) begin
`ifdef OBC_ROM_PIPE_EN
                    state_d = DRAIN;
`else
                    state_d = DONE;
`endif
                end
            end
            DRAIN: begin
                bus.busy = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                in_ready_c    = bus.out_ready;
                if (bus.out_ready) state_d = bus.in_valid ? SHIFT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready = in_ready;
        bus.plane_x  = (state_q == SHIFT) ? plane : '0;
        bus.plane_i  = (state_q == SHIFT) && last_plane;
        bus.out_data = (state_q == DONE) ? acc_q : '0;
    end

endmodule

// File: tb/tb_obc_plane_sequencer.sv
// Directed self-checking bench for obc_plane_sequencer (W=8), either ROM timing.
module tb_obc_plane_sequencer;
    import obc_pkg::*;

    localparam int W     = 8;
    localparam int ACC_W = 32 + W;
`ifdef OBC_ROM_PIPE_EN
    localparam int LAT = W + 2;
`else
    localparam int LAT = W + 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    obc_plane_sequencer_if #(.W(W)) bus ();

    obc_plane_sequencer #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ROM stage model: constant value, or the plane itself as an unsigned number.
    logic        rom_mode;
    logic [31:0] rom_const;
    logic [31:0] rom_val;
    always_comb rom_val = rom_mode ? {16'b0, bus.plane_x} : rom_const;
`ifdef OBC_ROM_PIPE_EN
    logic [31:0] rom_q = '0;
    always @(posedge clk) rom_q <= rom_val;
    assign bus.romout = rom_q;
`else
    assign bus.romout = rom_val;
`endif

    // With romout = plane value, the result is offset + sum_n (sample_n << n).
    function automatic logic [ACC_W-1:0] dft_model(input logic [16*W-1:0] d, input logic [31:0] off);
        logic [ACC_W-1:0] a;
        a = {{W{off[31]}}, off};
        for (int n = 0; n < 16; n++) a = a + (ACC_W'(d[n*W +: W]) << n);
        return a;
    endfunction

    task automatic load_vec(input logic [16*W-1:0] d, input logic [31:0] off);
        int guard;
        guard = 0;
        bus.in_data  = d;
        bus.offset   = off;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cnt);
        cnt = 0;
        while (bus.out_valid !== 1'b1 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_tests++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b, required 0 0 0",
                     bus.in_ready, bus.out_valid, bus.busy);
        end
        n_tests++;
        if (bus.out_data !== '0 || bus.plane_x !== '0 || bus.plane_i !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_data: out_data=%h plane_x=%h plane_i=%b, required 0",
                     bus.out_data, bus.plane_x, bus.plane_i);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: in_ready=%b, required 1", bus.in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_planes;
        logic [16*W-1:0] d;
        logic [7:0]      a5;
        int              cnt;
        a5        = 8'hA5;
        d         = '0;
        d[7:0]    = a5;
        rom_mode  = 1'b0;
        rom_const = 32'd0;
        load_vec(d, 32'd0);
        for (int b = 0; b < W; b++) begin
            n_tests++;
            if (bus.plane_x !== {15'b0, a5[b]} || bus.plane_i !== (b == W-1) || bus.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL planes_b%0d: plane_x=%h plane_i=%b busy=%b, required %h %b 1",
                         b, bus.plane_x, bus.plane_i, bus.busy, {15'b0, a5[b]}, (b == W-1));
            end
            @(negedge clk);
        end
        n_tests++;
        if (bus.plane_x !== '0 || bus.plane_i !== 1'b0) begin
            n_fail++;
            $display("FAIL planes_after: plane_x=%h plane_i=%b, required 0 0", bus.plane_x, bus.plane_i);
        end
        wait_out(cnt);
        n_tests++;
        if (1 + W + cnt !== LAT) begin
            n_fail++;
            $display("FAIL planes_latency: got %0d, required %0d", 1 + W + cnt, LAT);
        end
        n_tests++;
        if (bus.out_data !== '0) begin
            n_fail++;
            $display("FAIL planes_result: out_data=%h, required 0", bus.out_data);
        end
        @(negedge clk);
    endtask

    task automatic test_accumulate;
        logic [31:0]      offs [3];
        logic [31:0]      rcs  [3];
        logic [ACC_W-1:0] exps [3];
        int               cnt;
        offs[0] = 32'd0;  rcs[0] = 32'd1;          exps[0] = 40'd255;
        offs[1] = 32'd0;  rcs[1] = 32'hFFFF_FFFF;  exps[1] = 40'hFF_FFFF_FF01;
        offs[2] = 32'd10; rcs[2] = 32'd1;          exps[2] = 40'd265;
        rom_mode = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rom_const = rcs[k];
            load_vec(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, offs[k]);
            wait_out(cnt);
            n_tests++;
            if (cnt + 1 !== LAT) begin
                n_fail++;
                $display("FAIL accum%0d_latency: got %0d, required %0d", k, cnt + 1, LAT);
            end
            n_tests++;
            if (bus.out_data !== exps[k]) begin
                n_fail++;
                $display("FAIL accum%0d_result: out_data=%h, required %h", k, bus.out_data, exps[k]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure;
        int cnt;
        rom_mode      = 1'b0;
        rom_const     = 32'd1;
        bus.out_ready = 1'b0;
        load_vec(128'h1111_2222_3333_4444_5555_6666_7777_8888, 32'd0);
        wait_out(cnt);
        bus.in_data  = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
        bus.offset   = 32'd10;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 40'd255 || bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: out_valid=%b out_data=%h in_ready=%b busy=%b, required 1 ff 0 0",
                         k, bus.out_valid, bus.out_data, bus.in_ready, bus.busy);
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_ready_follow: in_ready=%b, required 1", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_handoff: out_valid=%b busy=%b, required 0 1", bus.out_valid, bus.busy);
        end
        wait_out(cnt);
        n_tests++;
        if (bus.out_data !== 40'd265) begin
            n_fail++;
            $display("FAIL bp_second_result: out_data=%h, required %h", bus.out_data, 40'd265);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [16*W-1:0]  v1, v2;
        logic [31:0]      o1, o2;
        logic [ACC_W-1:0] e1, e2;
        int               cnt, gap;
        logic             early_ok;
        v1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        v2 = 128'h8000_7F01_FF00_55AA_0F0F_F0F0_1122_3344;
        o1 = 32'h0000_1000;
        o2 = 32'hFFFF_FF00;
        e1 = dft_model(v1, o1);
        e2 = dft_model(v2, o2);
        rom_mode      = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_data   = v1;
        bus.offset    = o1;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        bus.in_data = v2;
        bus.offset  = o2;
        wait_out(cnt);
        n_tests++;
        if (cnt + 1 !== LAT) begin
            n_fail++;
            $display("FAIL b2b_latency: got %0d, required %0d", cnt + 1, LAT);
        end
        n_tests++;
        if (bus.out_data !== e1) begin
            n_fail++;
            $display("FAIL b2b_first_result: out_data=%h, required %h", bus.out_data, e1);
        end
        gap = 0;
        @(negedge clk);
        gap++;
        early_ok = (bus.busy === 1'b1) && (bus.out_valid === 1'b0);
        while (bus.out_valid !== 1'b1 && gap < 40) begin
            @(negedge clk);
            gap++;
        end
        bus.in_valid = 1'b0;
        n_tests++;
        if (!early_ok) begin
            n_fail++;
            $display("FAIL b2b_reload: second vector not loaded in the handoff cycle (busy 0 or out_valid 1), required busy=1 out_valid=0");
        end
        n_tests++;
        if (gap !== LAT) begin
            n_fail++;
            $display("FAIL b2b_period: out_valid gap=%0d, required %0d", gap, LAT);
        end
        n_tests++;
        if (bus.out_data !== e2) begin
            n_fail++;
            $display("FAIL b2b_second_result: out_data=%h, required %h", bus.out_data, e2);
        end
        @(negedge clk);
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_idle: out_valid=%b busy=%b in_ready=%b, required 0 0 1",
                     bus.out_valid, bus.busy, bus.in_ready);
        end
        rom_mode = 1'b0;
    endtask

    task automatic test_reset_mid;
        int   cnt;
        logic seen;
        rom_mode  = 1'b0;
        rom_const = 32'd1;
        load_vec({16{8'hFF}}, 32'd0);
        repeat (3) @(negedge clk);
        n_tests++;
        if (bus.plane_x !== 16'hFFFF || bus.busy !== 1'b1 || bus.plane_i !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_pre: plane_x=%h busy=%b plane_i=%b, required ffff 1 0",
                     bus.plane_x, bus.busy, bus.plane_i);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0 || bus.plane_x !== '0 || bus.plane_i !== 1'b0 ||
            bus.out_valid !== 1'b0 || bus.out_data !== '0) begin
            n_fail++;
            $display("FAIL rstmid_async: in_ready=%b busy=%b plane_x=%h plane_i=%b out_valid=%b out_data=%h, required all 0",
                     bus.in_ready, bus.busy, bus.plane_x, bus.plane_i, bus.out_valid, bus.out_data);
        end
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        rst = 1'b0;
        repeat (LAT + 2) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_no_output: out_valid seen=%b, required 0", seen);
        end
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_ready: in_ready=%b, required 1", bus.in_ready);
        end
        load_vec(128'hAAAA_5555_0000_FFFF_1234_5678_9ABC_DEF0, 32'd10);
        wait_out(cnt);
        n_tests++;
        if (cnt + 1 !== LAT) begin
            n_fail++;
            $display("FAIL rstmid_fresh_latency: got %0d, required %0d", cnt + 1, LAT);
        end
        n_tests++;
        if (bus.out_data !== 40'd265) begin
            n_fail++;
            $display("FAIL rstmid_fresh_result: out_data=%h, required %h", bus.out_data, 40'd265);
        end
        @(negedge clk);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.offset    = '0;
        bus.out_ready = 1'b1;
        rom_mode      = 1'b0;
        rom_const     = '0;
        #1 rst = 1'b1;
        test_reset;
        test_planes;
        test_accumulate;
        test_backpressure;
        test_back_to_back;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/obc_plane_sequencer.md
Name: obc_plane_sequencer

Overview:
- Bit-serial driver and accumulator for the OBC distributed-arithmetic 16-point DFT.
- Accepts 16 parallel two's-complement samples and streams them LSB-first as bit-planes (16 bits plus the sign-plane flag `i`) into the combinational OBC ROM/sign stage.
- Captures the returned 32-bit partial sum each cycle and shift-accumulates it into one DFT output term.
- Sits between the sample buffer and the ROM stage. One instance per ROM stage.

Parameters:
- W, 8, sample width in bits. This is the number of bit-planes per transform term. Range 2..16.
- ACC_W, 32+W, accumulator and output width. Derived; not user-overridden.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  sample vector valid.
- in_ready  out  1  sequencer can accept a vector.
- in_data  in  16*W  sample n in bits [n*W +: W], two's complement.
- offset  in  32  OBC offset constant, sampled at load.
- plane_x  out  16  bit b of each sample; bit n = sample n.
- plane_i  out  1  sign-plane flag; 1 only while b = W-1.
- romout  in  32  signed partial sum returned by the ROM stage.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  ACC_W  accumulated signed result.
- busy  out  1  high in SHIFT/DRAIN.

Behaviour:
- Reset state: IDLE. Outputs during reset:
  - in_ready=1 after reset release (0 while rst is high).
  - out_valid=0, out_data=0, plane_x=0, plane_i=0, busy=0.
  - Bit counter b=0, accumulator=0, shift register cleared.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_data into the shift register, load acc = sign-extend(offset) to ACC_W, set b=0, go to SHIFT.
- SHIFT, one cycle per plane b = 0..W-1:
  - plane_x[n] = bit b of sample n. plane_i = (b==W-1).
  - Same cycle, because the ROM stage is combinational: acc += sign-extend(romout) << b, computed in ACC_W with wrap-around (no saturation).
  - Samples shift right by one each cycle.
  - When b==W-1, go to DONE.
- Outside SHIFT: plane_x=0 and plane_i=0.
- DONE:
  - out_valid=1. out_data = final acc, held stable until out_valid&out_ready.
  - in_ready = out_ready, so a new vector can be accepted in the same cycle as the result handoff. This gives a back-to-back throughput of W+1 cycles per vector.
  - Handoff with in_valid=1: load and go to SHIFT.
  - Handoff with in_valid=0: go to IDLE.
- Latency: from the load cycle to the first out_valid is W+1 clocks.
- in_data and offset are ignored except in the load cycle.
- rst asserted mid-SHIFT or mid-DONE: abandon the current vector immediately and return to the reset state. No partial result is emitted.
- out_ready high while out_valid=0 has no effect.

Optional Feature:
- Macro: OBC_ROM_PIPE_EN.
- When defined, the ROM stage output is registered, so romout for plane b arrives one cycle after plane b is driven.
  - The sequencer delays accumulation by one cycle, using a registered copy of b.
  - A DRAIN state of one cycle follows SHIFT to absorb the final plane.
  - Latency becomes W+2; back-to-back throughput becomes W+2.
- When undefined: no DRAIN state exists; timing is as above.

Decomposition:
- Shared package obc_pkg holds:
  - State enum {IDLE, SHIFT, DRAIN, DONE}.
  - Constant OBC_ROM_W=32.
  - Constant OBC_NPTS=16.
  - Function acc_w(W) = OBC_ROM_W+W.
- One sub-module, obc_plane_shreg: a 16-lane W-bit parallel-load, right-shift register that presents the LSB of each lane as plane_x.

Test Plan:
- Planes: W=8, sample0=8'hA5, others 0, romout model returns 0.
  - Required: plane_x[0] over the 8 SHIFT cycles = 1,0,1,0,0,1,0,1.
  - Required: plane_i = 0 ×7, then 1.
  - Required: out_data=0.
- Accumulate: offset=0, romout fixed 32'd1 → out_data=255. Same with romout=32'hFFFFFFFF → out_data = −255 (ACC_W two's complement). Same with offset=32'd10 and romout=1 → 265.
- Backpressure: out_ready low for 5 cycles in DONE.
  - Required: out_data stable and out_valid held high.
  - Required: in_ready=0 until out_ready rises, then the handoff completes in one cycle.
- Back-to-back: in_valid held high with two vectors and out_ready=1.
  - Required: second load in the cycle of the first handoff.
  - Required: out_valid pulses 9 cycles apart (W=8). With OBC_ROM_PIPE_EN: 10 cycles apart, and results are unchanged against a delayed ROM model.
- Reset mid-op: assert rst at b=3 of SHIFT.
  - Required: outputs go to reset values asynchronously and no out_valid is produced.
  - Required: after release, in_ready=1 and a fresh vector processes correctly.
